// File: rtl/axi_result_writer.sv
// Result-stream sink: buffers 64B beats in a FIFO, cuts them into AXI4 INCR write bursts
// and writes them to host memory, pulsing done once every burst has been acknowledged.
module axi_result_writer #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned FIFO_DEPTH = 128,
  parameter int unsigned DESC_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [511:0]      data_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic              job_outputed_i,
  output logic              ready_o,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [511:0]      m_wdata,
  output logic [63:0]       m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned FPTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = FPTR_W + 1;
  localparam int unsigned DPTR_W = $clog2(DESC_DEPTH);
  localparam int unsigned DCNT_W = DPTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] dest_q, aw_off_q;
  logic [5:0]        cnt_q;
  logic              ready_q, ready_d;
  logic              error_q;

  // Beat FIFO
  logic [511:0]      fifo_mem [FIFO_DEPTH];
  logic [FPTR_W-1:0] f_wr_ptr_q, f_rd_ptr_q;
  logic [FCNT_W-1:0] f_cnt_q, f_cnt_d;

  // Burst descriptor queues (burst length - 1)
  logic [5:0]        aw_mem [DESC_DEPTH];
  logic [5:0]        w_mem  [DESC_DEPTH];
  logic [DPTR_W-1:0] aw_wr_ptr_q, aw_rd_ptr_q, w_wr_ptr_q, w_rd_ptr_q;
  logic [DCNT_W-1:0] aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;
  logic [DCNT_W-1:0] outst_q;

  // Channel output registers
  logic              awvalid_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [5:0]        awlen_q;
  logic              wvalid_q, wlast_q;
  logic [511:0]      wdata_q;
  logic [5:0]        w_rem_q;

  logic idle_start, accept, close_burst;
  logic aw_load, aw_fire, b_fire;
  logic w_slot_free, w_desc_pop, w_load;
  logic [5:0] aw_head, w_head;
  logic drained, run_d;

  assign idle_start  = (state_q == ST_IDLE) && start;
  assign accept      = valid_i && ready_q;
  assign close_burst = accept && (last_i || (cnt_q == 6'd63));

  assign aw_head = aw_mem[aw_rd_ptr_q];
  assign w_head  = w_mem[w_rd_ptr_q];

  // One AW in flight at a time keeps outstanding from overshooting DESC_DEPTH.
  assign aw_load = !awvalid_q && (aw_cnt_q != '0) && (outst_q < DCNT_W'(DESC_DEPTH));
  assign aw_fire = awvalid_q && m_awready;
  assign b_fire  = m_bvalid && m_bready;

  // Descriptor pop and first FIFO read happen together so the first beat follows by one cycle.
  assign w_slot_free = !wvalid_q || m_wready;
  assign w_load      = w_slot_free && (f_cnt_q != '0) && ((w_rem_q != '0) || (w_cnt_q != '0));
  assign w_desc_pop  = w_load && (w_rem_q == '0);

  assign f_cnt_d  = f_cnt_q + FCNT_W'(accept) - FCNT_W'(w_load);
  assign aw_cnt_d = aw_cnt_q + DCNT_W'(close_burst) - DCNT_W'(aw_load);
  assign w_cnt_d  = w_cnt_q + DCNT_W'(close_burst) - DCNT_W'(w_desc_pop);

  assign drained = (f_cnt_q == '0) && (cnt_q == '0) && (outst_q == '0) && (aw_cnt_q == '0) &&
                   (w_cnt_q == '0) && !awvalid_q && !wvalid_q && (w_rem_q == '0) && !accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (job_outputed_i) state_d = ST_DRAIN;
      ST_DRAIN: if (drained) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Two free beat slots and one free descriptor slot guarantee next cycle's accept fits.
  assign run_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign ready_d = run_d && (f_cnt_d <= FCNT_W'(FIFO_DEPTH - 2)) &&
                   (aw_cnt_d != DCNT_W'(DESC_DEPTH)) && (w_cnt_d != DCNT_W'(DESC_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
      dest_q   <= '0;
      aw_off_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (idle_start) begin
        dest_q  <= dest_addr;
        error_q <= 1'b0;
      end else if (b_fire && (m_bresp != 2'b00)) begin
        error_q <= 1'b1;
      end
      if (idle_start) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= close_burst ? 6'd0 : cnt_q + 6'd1;
      end
      if (idle_start) begin
        aw_off_q <= '0;
      end else if (aw_load) begin
        aw_off_q <= aw_off_q + ADDR_W'({({1'b0, aw_head} + 7'd1), 6'b0});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wr_ptr_q  <= '0;
      f_rd_ptr_q  <= '0;
      f_cnt_q     <= '0;
      aw_wr_ptr_q <= '0;
      aw_rd_ptr_q <= '0;
      aw_cnt_q    <= '0;
      w_wr_ptr_q  <= '0;
      w_rd_ptr_q  <= '0;
      w_cnt_q     <= '0;
    end else begin
      f_cnt_q  <= f_cnt_d;
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q  <= w_cnt_d;
      if (accept)      f_wr_ptr_q  <= f_wr_ptr_q + FPTR_W'(1);
      if (w_load)      f_rd_ptr_q  <= f_rd_ptr_q + FPTR_W'(1);
      if (close_burst) aw_wr_ptr_q <= aw_wr_ptr_q + DPTR_W'(1);
      if (close_burst) w_wr_ptr_q  <= w_wr_ptr_q + DPTR_W'(1);
      if (aw_load)     aw_rd_ptr_q <= aw_rd_ptr_q + DPTR_W'(1);
      if (w_desc_pop)  w_rd_ptr_q  <= w_rd_ptr_q + DPTR_W'(1);
    end
  end

  // Storage arrays carry no reset; pointers and counts define their validity.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[f_wr_ptr_q] <= data_i;
    if (close_burst) begin
      aw_mem[aw_wr_ptr_q] <= cnt_q;
      w_mem[w_wr_ptr_q]   <= cnt_q;
    end
    if (w_load) wdata_q <= fifo_mem[f_rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      outst_q   <= '0;
    end else begin
      if (aw_load) begin
        awvalid_q <= 1'b1;
        awaddr_q  <= dest_q + aw_off_q;
        awlen_q   <= aw_head;
      end else if (aw_fire) begin
        awvalid_q <= 1'b0;
      end
      outst_q <= outst_q + DCNT_W'(aw_fire) - DCNT_W'(b_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      w_rem_q  <= '0;
    end else begin
      if (w_load) begin
        wvalid_q <= 1'b1;
        if (w_desc_pop) begin
          w_rem_q <= w_head;
          wlast_q <= (w_head == 6'd0);
        end else begin
          w_rem_q <= w_rem_q - 6'd1;
          wlast_q <= (w_rem_q == 6'd1);
        end
      end else if (m_wready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign ready_o   = ready_q;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = {2'b00, awlen_q};
  assign m_awsize  = 3'd6;
  assign m_awburst = 2'b01;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;
  assign m_wlast   = wlast_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = (outst_q != '0);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_axi_result_writer.sv
// Randomized bench for axi_result_writer: a producer, an AXI slave with random back-pressure,
// and a reference model that derives expected bursts and beats straight from the job description.
module tb_axi_result_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  dest_addr;
  logic [511:0] data_i;
  logic         valid_i, last_i, job_outputed_i, ready_o;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;
  logic         busy, done, error;

  always #5 clk = ~clk;

  axi_result_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dest_addr(dest_addr),
    .data_i(data_i), .valid_i(valid_i), .last_i(last_i), .job_outputed_i(job_outputed_i),
    .ready_o(ready_o),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_t;

  // Reference model and bench state
  logic [511:0] beat_data[$];
  bit           beat_last[$];
  aw_t          exp_aw[$];
  logic [511:0] exp_wd[$];
  bit           exp_wl[$];
  int  nbeats, nbursts, bad_b, idx, cyc;
  int  aw_got, wl_got, b_sent, acc_cnt, wfire_cnt, done_cnt, low_level;
  int  stall_from, stall_to;
  bit  prod_on, jo_sent, acc_flag, b_fired, start_req, ready_low_seen, exp_err;

  // One cycle: drive inputs for the coming edge, then score the handshakes that edge will make.
  task automatic step();
    aw_t a;
    bit  was_acc;
    @(negedge clk);
    cyc++;
    was_acc = acc_flag;
    if (acc_flag) idx++;
    acc_flag = 0;
    start = start_req;
    start_req = 0;
    job_outputed_i = 0;
    if (prod_on && idx < nbeats) begin
      if (!valid_i || was_acc) valid_i = ($urandom_range(0, 3) != 0);
      data_i = beat_data[idx];
      last_i = beat_last[idx];
    end else begin
      valid_i = 0;
      last_i = 0;
      if (prod_on && idx == nbeats && !jo_sent) begin
        job_outputed_i = 1;
        jo_sent = 1;
      end
    end
    m_awready = ($urandom_range(0, 1) != 0);
    m_wready = (cyc >= stall_from && cyc < stall_to) ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (b_fired) m_bvalid = 0;
    b_fired = 0;
    if (!m_bvalid && b_sent < ((aw_got < wl_got) ? aw_got : wl_got)) begin
      m_bvalid = 1;
      m_bresp = (b_sent == bad_b) ? 2'b10 : 2'b00;
    end

    if (m_awvalid && m_awready) begin
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else begin
        a = exp_aw.pop_front();
        check("awaddr", m_awaddr, a.addr);
        check("awlen", m_awlen, a.len);
      end
      aw_got++;
    end
    if (m_wvalid && m_wready) begin
      if (exp_wd.size() == 0) check("w_unexpected", 1, 0);
      else begin
        check("wdata", m_wdata, exp_wd.pop_front());
        check("wlast", m_wlast, exp_wl.pop_front());
      end
      wfire_cnt++;
      if (m_wlast) wl_got++;
    end
    if (m_bvalid && m_bready) begin
      b_sent++;
      b_fired = 1;
    end
    if (valid_i && ready_o) begin
      acc_flag = 1;
      acc_cnt++;
    end
    if (cyc >= stall_from && cyc < stall_to && !ready_o && !ready_low_seen) begin
      ready_low_seen = 1;
      low_level = acc_cnt - wfire_cnt - (m_wvalid ? 1 : 0);
    end
    if (done) begin
      done_cnt++;
      check("error_at_done", error, exp_err);
    end
  endtask

  task automatic run_job(input int n, input bit cut64, input int bad, input int stall_len,
                         input int abort_at, input logic [63:0] dest);
    logic [63:0] off;
    int          c;
    bit          closing;
    logic [511:0] d;
    beat_data.delete(); beat_last.delete();
    exp_aw.delete(); exp_wd.delete(); exp_wl.delete();
    nbeats = n; bad_b = bad; nbursts = 0;
    off = '0; c = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      beat_data.push_back(d);
      beat_last.push_back(cut64 ? (((i + 1) % 64 == 0) || (i == n - 1)) : (i == n - 1));
      exp_wd.push_back(d);
      closing = beat_last[i] || (c == 63);
      exp_wl.push_back(closing);
      if (closing) begin
        exp_aw.push_back('{addr: dest + off, len: 8'(c)});
        off += 64'((c + 1) * 64);
        nbursts++;
        c = 0;
      end else begin
        c++;
      end
    end
    exp_err = (bad >= 0) && (bad < nbursts);
    idx = 0; aw_got = 0; wl_got = 0; b_sent = 0; acc_cnt = 0; wfire_cnt = 0; done_cnt = 0;
    jo_sent = 0; acc_flag = 0; ready_low_seen = 0; low_level = 0;
    stall_from = (stall_len > 0) ? cyc + 20 : -1;
    stall_to = (stall_len > 0) ? cyc + 20 + stall_len : -1;
    dest_addr = dest;
    start_req = 1;
    prod_on = 1;
    for (int k = 0; k < 8000 && done_cnt == 0; k++) begin
      step();
      if (abort_at >= 0 && wfire_cnt >= abort_at) break;
    end
    if (abort_at >= 0) begin
      rst_n = 0;
      #1;
      check("rst_mid_awvalid", m_awvalid, 0);
      check("rst_mid_wvalid", m_wvalid, 0);
      check("rst_mid_ready", ready_o, 0);
      check("rst_mid_busy", busy, 0);
      prod_on = 0; valid_i = 0; m_bvalid = 0; b_fired = 0; acc_flag = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      return;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    prod_on = 0;
    repeat (3) step();
    check("done_once", done_cnt, 1);
    check("idle_busy", busy, 0);
    check("idle_ready", ready_o, 0);
    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_wd.size(), 0);
    check("b_count", b_sent, nbursts);
    if (stall_len > 0) begin
      check("ready_fell", ready_low_seen, 1);
      check("fifo_level_ge126", (low_level >= 126), 1);
    end
  endtask

  initial begin
    logic [63:0] rd;
    rst_n = 0; start = 0; start_req = 0; dest_addr = '0; data_i = '0;
    valid_i = 0; last_i = 0; job_outputed_i = 0;
    m_awready = 0; m_wready = 0; m_bresp = 2'b00; m_bvalid = 0;
    prod_on = 0; b_fired = 0; cyc = 0; stall_from = -1; stall_to = -1; bad_b = -1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_bready", m_bready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst_n = 1;
    @(negedge clk);
    check("awsize", m_awsize, 3'd6);
    check("awburst", m_awburst, 2'b01);
    check("wstrb", m_wstrb, {64{1'b1}});

    run_job(64, 1, -1, 0, -1, 64'h1000_0000);
    run_job(130, 1, -1, 0, -1, 64'h1000_0000);
    run_job(300, 1, -1, 200, -1, 64'h2000_0000);
    run_job(100, 0, -1, 0, -1, 64'h3000_0000);
    run_job(130, 1, 1, 0, -1, 64'h4000_0000);
    check("error_sticky", error, 1);
    run_job(64, 1, -1, 0, -1, 64'h5000_0000);
    check("error_cleared", error, 0);
    run_job(200, 1, -1, 0, 70, 64'h6000_0000);
    run_job(64, 1, -1, 0, -1, 64'h7000_0000);
    run_job(150, 1, -1, 0, -1, 64'hFFFF_FFFF_FFFF_F000);
    for (int j = 0; j < 4; j++) begin
      rd = {$urandom, $urandom} & ~64'hFFF;
      run_job($urandom_range(1, 300), 1'($urandom_range(0, 1)), $urandom_range(0, 3) - 1, 0, -1,
              rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
